ui_key_ctrl: RTL
================

// Module: ui_key_ctrl
// PURPOSE
//  Front-panel input end of the clock/calendar: conditions raw push-buttons and drives the
//  mode/setup/adjust controls consumed by the time/date counter top level.
//  Synchronises, debounces and edge-detects keys; runs the setup-field FSM; produces
//  auto-repeating adjust strobes on held up/down keys.
// PARAMETERS
//  DB_CYCLES      1_000_000   clk cycles a raw key must be stable to be accepted (20 ms @50 MHz)
//  REPEAT_DELAY   25_000_000  cycles held before first auto-repeat (0.5 s)
//  REPEAT_PERIOD  5_000_000   cycles between auto-repeats (0.1 s)
//  CNT_W          25          width of debounce/repeat counters; must hold max of the above
// PORTS
//  clk                 in   1  system clock
//  rst                 in   1  asynchronous, active-high reset
//  key_mode_n          in   1  raw key, active-low: step setup field
//  key_swap_n          in   1  raw key, active-low: toggle time/date view
//  key_up_n            in   1  raw key, active-low: increment selected field
//  key_down_n          in   1  raw key, active-low: decrement selected field
//  display             out  1  1 = setup mode active
//  swap_display        out  1  0 = time view, 1 = date view
//  setup_second_day    out  1  active-low: sec (time view) / day (date view) selected
//  setup_minute_month  out  1  active-low: min / month selected
//  setup_hour_year     out  1  active-low: hour / year selected
//  inc_dec             out  1  direction of current/last adjust: 1 = up, 0 = down
//  adj_stb             out  1  one-cycle adjust pulse, valid only while display = 1
// BEHAVIOUR
//  Reset: state RUN; display=0, swap_display=0, all setup_*=1, inc_dec=1, adj_stb=0;
//   all debounced keys = released; all counters = 0.
//  Per key: 2-FF synchroniser -> debounce counter; counter clears when sync != debounced,
//   else counts; at DB_CYCLES-1 debounced takes sync value and counter clears.
//  press pulse: one cycle on debounced 1->0. Release generates nothing.
//  Latency: raw edge held stable -> press pulse exactly DB_CYCLES+3 clk edges later.
//  Glitch shorter than DB_CYCLES: no press, no output change.
//  FSM states RUN, SET_S, SET_M, SET_H; mode press: RUN->SET_S->SET_M->SET_H->RUN.
//   RUN: display=0, setup_*=1. SET_S/M/H: display=1, only the matching setup_* = 0.
//  Outputs registered: update the cycle after the press pulse.
//  swap press toggles swap_display in any state; FSM state unchanged.
//  Adjust (only in SET_*): up press -> inc_dec=1 + adj_stb; down press -> inc_dec=0 + adj_stb.
//   Same-cycle registration as FSM outputs; inc_dec holds after strobe.
//  Auto-repeat: while that key stays debounced-pressed, repeat counter runs;
//   first extra adj_stb REPEAT_DELAY cycles after the press strobe,
//   then every REPEAT_PERIOD cycles; counter clears on release.
//  Both up and down debounced-pressed: no adj_stb, repeat counter held at 0;
//   on release of one, the other does not strobe until newly pressed.
//  Mode press same cycle as adjust/repeat: mode wins, adj_stb suppressed that cycle.
//  Mode press while up held: repeat counter clears; no strobe until the key is re-pressed.
//  In RUN: up/down ignored entirely, adj_stb=0, inc_dec unchanged.
//  rst mid-hold: all returns to reset values; a key still held after rst deassert is seen
//   as pressed after DB_CYCLES+3 and generates a press.
// TESTING (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6)
//  1 reset, pulse key_mode_n low 10 cyc -> display 1, setup_second_day 0 at edge 7; 3 more presses -> RUN, all setup_* 1.
//  2 key_up_n glitch low 2 cyc -> no output change; key_swap_n low 10 cyc -> swap_display 0->1 once.
//  3 SET_M, hold key_up_n 60 cyc -> adj_stb at t0, t0+20, t0+26, t0+32 ...; inc_dec=1 throughout.
//  4 SET_H, press key_down_n -> one adj_stb, inc_dec=0; in RUN press key_up_n -> no adj_stb, inc_dec stays 0.
//  5 SET_S, up and down held together 40 cyc -> zero adj_stb; mode press same cycle as up press -> SET_M, no strobe.
//  6 assert rst while up held in SET_M -> immediate reset values; keep key held -> state RUN, no adj_stb.

Source files
------------

// File: rtl/ui_key_ctrl.sv
// Front-panel key conditioning for the clock/calendar: synchronise, debounce and edge-detect
// four raw keys, step the setup-field FSM and generate auto-repeating adjust strobes.
module ui_key_ctrl #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic key_mode_n,
    input  logic key_swap_n,
    input  logic key_up_n,
    input  logic key_down_n,
    output logic display,
    output logic swap_display,
    output logic setup_second_day,
    output logic setup_minute_month,
    output logic setup_hour_year,
    output logic inc_dec,
    output logic adj_stb
);

    localparam int NK     = 4;
    localparam int K_MODE = 0;
    localparam int K_SWAP = 1;
    localparam int K_UP   = 2;
    localparam int K_DOWN = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_S = 2'd1,
        SET_M = 2'd2,
        SET_H = 2'd3
    } state_t;

    logic [NK-1:0]   key_raw;
    logic [NK-1:0]   key_press;
    logic [K_DOWN:K_UP] key_level;

    assign key_raw = {key_down_n, key_up_n, key_swap_n, key_mode_n};

    // One conditioning channel per key; levels stay active-low like the raw inputs.
    generate
        for (genvar gi = 0; gi < NK; gi++) begin : g_key
            logic             meta_reg;
            logic             sync_reg;
            logic             deb_reg;
            logic             deb_prev_reg;
            logic [CNT_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg     <= 1'b1;
                    sync_reg     <= 1'b1;
                    deb_reg      <= 1'b1;
                    deb_prev_reg <= 1'b1;
                    db_cnt_reg   <= '0;
                end else begin
                    meta_reg     <= key_raw[gi];
                    sync_reg     <= meta_reg;
                    deb_prev_reg <= deb_reg;
                    if (sync_reg == deb_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                        deb_reg    <= sync_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign key_press[gi] = deb_prev_reg & ~deb_reg;

            if (gi >= K_UP) begin : g_level
                assign key_level[gi] = deb_reg;
            end
        end
    endgenerate

    state_t           state_reg, state_next;
    logic             display_reg, display_next;
    logic [2:0]       setup_reg, setup_next;
    logic             swap_reg, swap_next;
    logic             inc_dec_reg, inc_dec_next;
    logic             adj_stb_reg, adj_stb_next;
    logic             rpt_act_reg, rpt_act_next;
    logic             rpt_up_reg, rpt_up_next;
    logic             rpt_first_reg, rpt_first_next;
    logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;

    logic             both_held;
    logic             rpt_held;
    logic [CNT_W-1:0] rpt_limit;

    assign both_held = ~key_level[K_UP] & ~key_level[K_DOWN];
    assign rpt_held  = rpt_up_reg ? ~key_level[K_UP] : ~key_level[K_DOWN];
    assign rpt_limit = rpt_first_reg ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            display_reg   <= 1'b0;
            setup_reg     <= 3'b111;
            swap_reg      <= 1'b0;
            inc_dec_reg   <= 1'b1;
            adj_stb_reg   <= 1'b0;
            rpt_act_reg   <= 1'b0;
            rpt_up_reg    <= 1'b1;
            rpt_first_reg <= 1'b1;
            rpt_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            display_reg   <= display_next;
            setup_reg     <= setup_next;
            swap_reg      <= swap_next;
            inc_dec_reg   <= inc_dec_next;
            adj_stb_reg   <= adj_stb_next;
            rpt_act_reg   <= rpt_act_next;
            rpt_up_reg    <= rpt_up_next;
            rpt_first_reg <= rpt_first_next;
            rpt_cnt_reg   <= rpt_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        swap_next      = swap_reg ^ key_press[K_SWAP];
        inc_dec_next   = inc_dec_reg;
        adj_stb_next   = 1'b0;
        rpt_act_next   = rpt_act_reg;
        rpt_up_next    = rpt_up_reg;
        rpt_first_next = rpt_first_reg;
        rpt_cnt_next   = rpt_cnt_reg;

        // Priority: mode step, then inhibit conditions, then fresh presses, then repeat.
        if (key_press[K_MODE]) begin
            unique case (state_reg)
                RUN:     state_next = SET_S;
                SET_S:   state_next = SET_M;
                SET_M:   state_next = SET_H;
                SET_H:   state_next = RUN;
                default: state_next = RUN;
            endcase
            rpt_act_next = 1'b0;
            rpt_cnt_next = '0;
        end else if (state_reg == RUN || both_held) begin
            rpt_act_next = 1'b0;
            rpt_cnt_next = '0;
        end else if (key_press[K_UP] || key_press[K_DOWN]) begin
            inc_dec_next   = key_press[K_UP];
            adj_stb_next   = 1'b1;
            rpt_act_next   = 1'b1;
            rpt_up_next    = key_press[K_UP];
            rpt_first_next = 1'b1;
            rpt_cnt_next   = CNT_W'(1);
        end else if (rpt_act_reg) begin
            if (!rpt_held) begin
                rpt_act_next = 1'b0;
                rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == rpt_limit) begin
                adj_stb_next   = 1'b1;
                rpt_first_next = 1'b0;
                rpt_cnt_next   = CNT_W'(1);
            end else begin
                rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
        end
    end

    // Field selects are decoded from the next state so they change with display.
    always_comb begin
        display_next = (state_next != RUN);
        setup_next   = 3'b111;
        unique case (state_next)
            SET_S:   setup_next = 3'b011;
            SET_M:   setup_next = 3'b101;
            SET_H:   setup_next = 3'b110;
            default: setup_next = 3'b111;
        endcase
    end

    assign display            = display_reg;
    assign swap_display       = swap_reg;
    assign setup_second_day   = setup_reg[2];
    assign setup_minute_month = setup_reg[1];
    assign setup_hour_year    = setup_reg[0];
    assign inc_dec            = inc_dec_reg;
    assign adj_stb            = adj_stb_reg;

endmodule
